// File: rtl/softmax_row_scheduler.sv
// Row-by-row sequencer for the softmax pipeline: loader -> softmax core -> flattener.
// Waits on each stage's done with a per-wait timeout, then reads the finished row back from port B.
module softmax_row_scheduler #(
  parameter int NUM_ROWS = 32,
  parameter int ROW_LEN  = 32,
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 1024,
  localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_load_start,
  output logic [ROW_W-1:0]  o_load_row,
  input  logic              i_load_done,
  input  logic              i_sm_valid,
  input  logic              i_wr_done,
  output logic [ADDR_W-1:0] o_wr_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  // state   | meaning
  // IDLE    | waiting for i_start
  // LOAD    | one-cycle load start pulse for the current row
  // WAIT_LD | waiting for the row loader
  // WAIT_SM | waiting for the softmax core result
  // WAIT_WR | waiting for the flattener to finish writing the row
  // READ    | ROW_LEN-cycle readback of the row from port B
  // NEXT    | advance row, or pulse o_done after the last row
  // ERR     | a wait timed out; o_error held until i_start
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_LD, S_WAIT_SM, S_WAIT_WR, S_READ, S_NEXT, S_ERR
  } state_t;

  localparam int K_W   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [K_W-1:0]    K_LAST   = K_W'(ROW_LEN - 1);
  localparam logic [K_W-1:0]    K_ONE    = K_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_INIT = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

  state_t           state;
  logic [K_W-1:0]   k;
  logic [TMR_W-1:0] timer;
  logic             awaited;

  always_comb begin
    awaited = 1'b0;
    case (state)
      S_WAIT_LD: awaited = i_load_done;
      S_WAIT_SM: awaited = i_sm_valid;
      S_WAIT_WR: awaited = i_wr_done;
      default:   awaited = 1'b0;
    endcase
  end

  // Timer is a down-counter reloaded on every wait-state entry; reaching zero with
  // the awaited done still low is the timeout. Done is checked first so it wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      k            <= '0;
      timer        <= '0;
      o_load_start <= 1'b0;
      o_load_row   <= '0;
      o_wr_base    <= '0;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_load_start <= 1'b0;
      o_done       <= 1'b0;
      if (i_abort) begin
        state   <= S_IDLE;
        o_rd_en <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (i_start) begin
              state        <= S_LOAD;
              o_error      <= 1'b0;
              o_load_row   <= '0;
              o_wr_base    <= '0;
              o_load_start <= 1'b1;
              o_busy       <= 1'b1;
            end
          end
          S_LOAD: begin
            state <= S_WAIT_LD;
            timer <= TMR_INIT;
          end
          S_WAIT_LD, S_WAIT_SM, S_WAIT_WR: begin
            if (awaited) begin
              timer <= TMR_INIT;
              if (state == S_WAIT_LD) begin
                state <= S_WAIT_SM;
              end else if (state == S_WAIT_SM) begin
                state <= S_WAIT_WR;
              end else begin
                state     <= S_READ;
                k         <= '0;
                o_rd_en   <= 1'b1;
                o_rd_addr <= o_wr_base;
              end
            end else if (timer == '0) begin
              state   <= S_ERR;
              o_error <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              timer <= timer - TMR_ONE;
            end
          end
          S_READ: begin
            if (k == K_LAST) begin
              state   <= S_NEXT;
              o_rd_en <= 1'b0;
              o_done  <= (o_load_row == ROW_LAST);
            end else begin
              k         <= k + K_ONE;
              o_rd_addr <= o_rd_addr + ADDR_ONE;
            end
          end
          S_NEXT: begin
            if (o_load_row == ROW_LAST) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state        <= S_LOAD;
              o_load_row   <= o_load_row + ROW_ONE;
              o_wr_base    <= o_wr_base + ROW_STEP;
              o_load_start <= 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            o_rd_en <= 1'b0;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Self-checking bench for softmax_row_scheduler: scenario tasks plus a readback scoreboard.
`timescale 1ns/1ps
module tb_softmax_row_scheduler;

  localparam int NR = 2;
  localparam int RL = 32;
  localparam int AW = 10;
  localparam int TO = 16;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start, i_abort, i_load_done, i_sm_valid, i_wr_done;
  logic          o_load_start, o_rd_en, o_busy, o_done, o_error;
  logic [RW-1:0] o_load_row;
  logic [AW-1:0] o_wr_base, o_rd_addr;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [AW-1:0] exp_q[$];

  softmax_row_scheduler #(.NUM_ROWS(NR), .ROW_LEN(RL), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .o_load_start(o_load_start), .o_load_row(o_load_row),
    .i_load_done(i_load_done), .i_sm_valid(i_sm_valid), .i_wr_done(i_wr_done),
    .o_wr_base(o_wr_base), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Readback scoreboard: every strobe must match the next expected address.
  always begin
    @(posedge i_clk);
    #1;
    if (o_rd_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: addr=%0d with no expected read", o_rd_addr);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (o_rd_addr !== e) begin
          errors++;
          $display("FAIL rd_addr: got %0d expected %0d", o_rd_addr, e);
        end
      end
    end
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_row(input int r);
    for (int k = 0; k < RL; k++) exp_q.push_back(AW'(r * RL + k));
  endtask

  // Entered in the LOAD cycle of row r; leaves one cycle after NEXT.
  task automatic run_row(input int r, input int dly);
    checks++;
    if (o_load_start !== 1'b1) begin
      errors++; $display("FAIL load_start row%0d: got %b expected 1", r, o_load_start);
    end
    checks++;
    if (o_load_row !== RW'(r)) begin
      errors++; $display("FAIL load_row: got %0d expected %0d", o_load_row, r);
    end
    checks++;
    if (o_wr_base !== AW'(r * RL)) begin
      errors++; $display("FAIL wr_base: got %0d expected %0d", o_wr_base, r * RL);
    end
    tick();
    repeat (dly) tick();
    i_load_done = 1'b1; tick(); i_load_done = 1'b0;
    repeat (dly) tick();
    i_sm_valid = 1'b1; tick(); i_sm_valid = 1'b0;
    repeat (dly) tick();
    i_wr_done = 1'b1; push_row(r); tick(); i_wr_done = 1'b0;
    repeat (RL) tick();
    checks++;
    if (o_done !== ((r == NR - 1) ? 1'b1 : 1'b0)) begin
      errors++; $display("FAIL done_in_next row%0d: got %b", r, o_done);
    end
    checks++;
    if (o_rd_en !== 1'b0) begin
      errors++; $display("FAIL rd_en_in_next row%0d: got %b expected 0", r, o_rd_en);
    end
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_start = 0; i_abort = 0; i_load_done = 0; i_sm_valid = 0; i_wr_done = 0;
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_load_start, o_rd_en, o_busy, o_done, o_error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
                         {o_load_start, o_rd_en, o_busy, o_done, o_error});
    end
    checks++;
    if (o_load_row !== '0 || o_wr_base !== '0 || o_rd_addr !== '0) begin
      errors++; $display("FAIL reset_buses: row=%0d base=%0d addr=%0d expected 0",
                         o_load_row, o_wr_base, o_rd_addr);
    end
    tick(); tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_two_rows();
    int d0;
    d0 = done_cnt;
    i_start = 1'b1; tick(); i_start = 1'b0;
    run_row(0, 3);
    run_row(1, 3);
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_run: got %b expected 0", o_busy);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL done_count: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL reads_missing: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_out_of_order();
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    i_load_done = 1'b1; tick(); i_load_done = 1'b0;
    i_wr_done = 1'b1; tick(); i_wr_done = 1'b0;
    tick(); tick();
    i_sm_valid = 1'b1; tick(); i_sm_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (o_rd_en !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL early_wr_done: rd_en=%b busy=%b expected 0/1", o_rd_en, o_busy);
    end
    i_wr_done = 1'b1; push_row(0); tick(); i_wr_done = 1'b0;
    checks++;
    if (o_rd_en !== 1'b1) begin
      errors++; $display("FAIL read_after_wr: got %b expected 1", o_rd_en);
    end
    repeat (RL) tick();
    checks++;
    if (o_done !== 1'b0) begin
      errors++; $display("FAIL ooo_done_row0: got %b expected 0", o_done);
    end
    tick();
    run_row(1, 0);
    tick();
  endtask

  task automatic test_timeout();
    int d0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    i_load_done = 1'b1; tick(); i_load_done = 1'b0;
    repeat (TO - 1) tick();
    checks++;
    if (o_busy !== 1'b1 || o_error !== 1'b0) begin
      errors++; $display("FAIL pre_timeout: busy=%b error=%b expected 1/0", o_busy, o_error);
    end
    tick();
    checks++;
    if (o_error !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_err: error=%b busy=%b expected 1/0", o_error, o_busy);
    end
    tick(); tick();
    checks++;
    if (o_error !== 1'b1 || o_rd_en !== 1'b0 || o_load_start !== 1'b0) begin
      errors++; $display("FAIL err_hold: error=%b rd_en=%b ld=%b expected 1/0/0",
                         o_error, o_rd_en, o_load_start);
    end
    d0 = done_cnt;
    i_start = 1'b1; tick(); i_start = 1'b0;
    checks++;
    if (o_error !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b expected 0", o_error);
    end
    run_row(0, 1);
    run_row(1, 1);
    tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL restart_done: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick();
    i_load_done = 1'b1; tick(); i_load_done = 1'b0;
    tick();
    i_sm_valid = 1'b1; tick(); i_sm_valid = 1'b0;
    tick();
    i_wr_done = 1'b1; push_row(0); tick(); i_wr_done = 1'b0;
    repeat (10) tick();
    checks++;
    if (o_rd_addr !== AW'(10)) begin
      errors++; $display("FAIL abort_at_k10: addr=%0d expected 10", o_rd_addr);
    end
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    checks++;
    if (o_rd_en !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL abort_stop: rd_en=%b busy=%b expected 0/0", o_rd_en, o_busy);
    end
    checks++;
    if (exp_q.size() !== RL - 11) begin
      errors++; $display("FAIL abort_reads: left=%0d expected %0d", exp_q.size(), RL - 11);
    end
    exp_q.delete();
    tick(); tick();
    checks++;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0);
    end
    i_start = 1'b1; tick(); i_start = 1'b0;
    run_row(0, 2);
    run_row(1, 2);
    tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL abort_rerun_done: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_ignored_start();
    i_start = 1'b1; i_abort = 1'b1; tick(); i_start = 1'b0; i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_load_start !== 1'b0 || o_load_row !== RW'(NR - 1)) begin
      errors++; $display("FAIL start_abort_idle: busy=%b ld=%b row=%0d expected 0/0/%0d",
                         o_busy, o_load_start, o_load_row, NR - 1);
    end
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    checks++;
    if (o_load_start !== 1'b0 || o_busy !== 1'b1 || o_load_row !== RW'(0)) begin
      errors++; $display("FAIL start_while_busy: ld=%b busy=%b row=%0d expected 0/1/0",
                         o_load_start, o_busy, o_load_row);
    end
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int d0;
    d0 = done_cnt;
    i_start = 1'b1; tick(); i_start = 1'b0;
    run_row(0, 3);
    tick();
    i_load_done = 1'b1; tick(); i_load_done = 1'b0;
    i_sm_valid = 1'b1; tick(); i_sm_valid = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b1 || o_wr_base !== AW'(RL)) begin
      errors++; $display("FAIL pre_reset_state: busy=%b base=%0d expected 1/%0d",
                         o_busy, o_wr_base, RL);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_load_start, o_rd_en, o_busy, o_done, o_error} !== 5'b0 ||
        o_load_row !== '0 || o_wr_base !== '0 || o_rd_addr !== '0) begin
      errors++; $display("FAIL async_reset: busy=%b row=%0d base=%0d expected all 0",
                         o_busy, o_load_row, o_wr_base);
    end
    tick(); tick();
    i_rst = 1'b0;
    tick();
    checks++;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL reset_no_done: got %0d expected %0d", done_cnt, d0);
    end
    i_start = 1'b1; tick(); i_start = 1'b0;
    run_row(0, 3);
    run_row(1, 3);
    tick();
    checks++;
    if (done_cnt - d0 !== 1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_run: done=%0d busy=%b expected 1/0",
                         done_cnt - d0, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_two_rows();
    test_out_of_order();
    test_timeout();
    test_abort();
    test_ignored_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
